// File: rtl/mult_div_unit_pkg.sv
// Shared core definitions for the multiply/divide unit: op encodings,
// FSM state encoding and the datapath width used by the ULA as well.
package mult_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_negate.sv
// Conditional two's-complement: passes value through, or negates it when neg is set.
module md_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Works on operand magnitudes, one shift-add or restoring step per cycle.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO honoured here
// CALC    | WIDTH iteration steps on the latched magnitudes
// FIX     | sign fix-up, HI/LO write, done pulse
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state;
    md_op_t             op_q;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [CW-1:0]      cnt;
    logic               sign_q;
    logic               sign_r;
    logic               div_zero;

    logic               signed_op;
    logic               is_div;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] fix_in;
    logic [2*WIDTH-1:0] fix_main;
    logic [WIDTH-1:0]   fix_rem;
    logic               unused_trial_msb;

    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);

    md_negate #(.W(WIDTH)) u_abs_a (.value(In1), .neg(signed_op & In1[WIDTH-1]), .result(abs_a));
    md_negate #(.W(WIDTH)) u_abs_b (.value(In2), .neg(signed_op & In2[WIDTH-1]), .result(abs_b));

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_reg[0] ? {1'b0, a_reg} : '0);

    // Partial remainder extended by one bit so the trial subtraction cannot wrap.
    assign div_shift = {rem, a_reg[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_reg};
    assign div_trial = div_shift - {1'b0, b_reg};
    assign unused_trial_msb = div_trial[WIDTH];

    // Division by zero keeps raw magnitudes: quotient all-ones, remainder = |dividend|.
    assign fix_in = is_div ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;
    md_negate #(.W(2*WIDTH)) u_fix_main (.value(fix_in), .neg(sign_q & ~div_zero), .result(fix_main));
    md_negate #(.W(WIDTH))   u_fix_rem  (.value(rem), .neg(sign_r & ~div_zero), .result(fix_rem));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= MD_MULT;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q     <= md_op_t'(op);
                        a_reg    <= abs_a;
                        b_reg    <= abs_b;
                        sign_q   <= signed_op & (In1[WIDTH-1] ^ In2[WIDTH-1]);
                        sign_r   <= signed_op & In1[WIDTH-1];
                        div_zero <= op[1] && (In2 == '0);
                        acc      <= '0;
                        rem      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_CALC;
                    end else begin
                        busy <= 1'b0;
                        if (!busy) begin
                            if (mthi_we) hi <= mt_data;
                            if (mtlo_we) lo <= mt_data;
                        end
                    end
                end
                ST_CALC: begin
                    if (is_div) begin
                        rem              <= div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        a_reg            <= a_reg << 1;
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc   <= {mul_sum, acc[WIDTH-1:1]};
                        b_reg <= b_reg >> 1;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi    <= is_div ? fix_rem : fix_main[2*WIDTH-1:WIDTH];
                    lo    <= fix_main[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + random bench for mult_div_unit with a result scoreboard and a reference model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         mthi_we = 1'b0;
    logic         mtlo_we = 1'b0;
    logic [W-1:0] mt_data = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int total = 0;
    int passed = 0;
    int failed = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] cur_hi = '0;
    logic [W-1:0] cur_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .In1(in1), .In2(in2), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
        .mt_data(mt_data), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} for one operation, MIPS semantics (truncating division).
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb_, q, r;
        logic [63:0]  p;
        logic [W-1:0] mag;
        sa  = $signed(a);
        sb_ = $signed(b);
        mag = a[W-1] ? (~a + 32'd1) : a;
        case (o)
            2'b00: begin p = sa * sb_; return p; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
            2'b10: begin
                if (b == '0) return {mag, 32'hFFFF_FFFF};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == '0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag, input int inj);
        logic [63:0] m;
        exp_t        e;
        int          lat;
        m = model(o, a, b);
        e.tag = tag;
        e.hi  = m[63:32];
        e.lo  = m[31:0];
        sb.push_back(e);
        @(negedge clk);
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = ~o; in1 = ~a; in2 = ~b;
        lat = 0;
        chk({tag, "_busy_on"}, {63'd0, busy}, 64'd1);
        while (done !== 1'b1 && lat < 60) begin
            if (lat == inj) begin
                start = 1'b1; mthi_we = 1'b1; mt_data = 32'h1234;
            end else begin
                start = 1'b0; mthi_we = 1'b0;
            end
            if (lat == 20) begin
                chk({tag, "_hold_hi"}, {32'd0, hi}, {32'd0, cur_hi});
                chk({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, cur_lo});
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0; mthi_we = 1'b0;
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
            chk({e.tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
            cur_hi = e.hi;
            cur_lo = e.lo;
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic done_seen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5,        "mult_neg3x5", -1);
        chk("mult_neg3x5_plan_hi", {32'd0, cur_hi}, 64'hFFFF_FFFF);
        chk("mult_neg3x5_plan_lo", {32'd0, cur_lo}, 64'hFFFF_FFF1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", -1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,        "div_neg7by2", -1);
        run_op(2'b11, 32'd100,       32'd7,        "divu_100by7", -1);
        run_op(2'b11, 32'd5,         32'd0,        "divu_by0", -1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", -1);
        run_op(2'b10, 32'hFFFF_FFF7, 32'd0,        "div_neg_by0", -1);
        run_op(2'b00, 32'h0001_2345, 32'hFFFF_FFB3, "mult_inject", 10);

        for (int i = 0; i < 6; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op(ro, ra, rb, "rnd", -1);
        end

        @(negedge clk);
        mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'h55;
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        chk("mt_both_hi", {32'd0, hi}, 64'h55);
        chk("mt_both_lo", {32'd0, lo}, 64'h55);

        @(negedge clk);
        op = 2'b10; in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            done_seen = done_seen | done;
        end
        chk("midrst_no_done", {63'd0, done_seen}, 64'd0);
        chk("midrst_hi_after", {32'd0, hi}, 64'd0);

        mtlo_we = 1'b1; mt_data = 32'hAB;
        @(negedge clk);
        mtlo_we = 1'b0;
        chk("mtlo_lo", {32'd0, lo}, 64'hAB);
        chk("mtlo_hi", {32'd0, hi}, 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS core. It executes MULT, MULTU, DIV and DIVU, which the single-cycle ULA does not implement. Operands are taken from the same register-file read ports that feed the ULA, and the unit owns the architectural HI/LO registers. The control unit starts an operation with a one-cycle pulse, stalls on `busy`, and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be even and ≥ 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `op`  in  2  operation select:
  - `00` MULT
  - `01` MULTU
  - `10` DIV
  - `11` DIVU
- `In1`  in  WIDTH  multiplicand / dividend (rs).
- `In2`  in  WIDTH  multiplier / divisor (rt).
- `mthi_we`, `mtlo_we`  in  1  MTHI/MTLO write enables.
- `mt_data`  in  WIDTH  write data for MTHI/MTLO.
- `hi`, `lo`  out  WIDTH  architectural HI/LO; reset 0.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive; reset 0.
- `done`  out  1  one-cycle pulse in the cycle HI/LO take the new result; reset 0.

## Operation
- **FSM states:** IDLE → CALC → FIX → IDLE.
- **IDLE:**
  - On `start`, latch `op`.
  - Latch |In1| and |In2| for signed ops, raw values for unsigned ops.
  - Latch the result sign flags: product/quotient sign = In1[MSB]^In2[MSB]; remainder sign = In1[MSB]. Flags are 0 for unsigned ops.
  - Clear the 2·WIDTH accumulator and the step counter; go to CALC.
- **CALC, multiply:** one shift-add step per cycle on a 2·WIDTH accumulator.
- **CALC, divide:** one restoring step per cycle. The remainder is WIDTH+1 bits so the trial subtraction never overflows.
- **CALC exit:** after exactly WIDTH steps (counter reaches WIDTH-1), go to FIX.
- **FIX, normal results:**
  - Apply two's-complement negation per the sign flags.
  - Multiply writes {hi, lo} = the 2·WIDTH product.
  - Divide writes lo = quotient, hi = remainder.
  - Assert `done`; go to IDLE.
- **Divide by zero (In2 = 0):**
  - No special path. The restoring algorithm yields quotient all-ones and remainder = the latched dividend magnitude.
  - FIX skips sign correction, so lo = all-ones and hi = In1 when In1 is non-negative.
  - For signed DIV with negative In1, hi = |In1|. This is documented as architecturally UNPREDICTABLE; software must not rely on it.
- **Overflow, DIV 0x80000000 / -1:** lo = 0x80000000, hi = 0. This falls out of the magnitude path with no special handling.
- **MTHI/MTLO:**
  - Honoured only in IDLE when `start` is low.
  - Ignored while busy or when coincident with `start`. The controller must not issue them then.
  - Both may write in the same cycle.
- **`start` while busy:** ignored; no queueing.
- **`op` and `In1`/`In2` after acceptance:** don't-care; the unit uses its latched copies.

## Timing
- `start` sampled at edge 0 → `busy` high from edge 0 → `done` high and hi/lo updated at edge WIDTH+1 (33 for WIDTH = 32). `busy` falls at edge WIDTH+2.
- **Back-to-back:** a new `start` is accepted in the cycle `done` falls, i.e. the first IDLE cycle.
- `hi`/`lo` hold their previous values throughout CALC.
- **MTHI/MTLO:** `hi`/`lo` update on the edge where `mthi_we`/`mtlo_we` is sampled high.
- **Reset asserted mid-operation:** immediately returns to IDLE and clears `hi`, `lo`, `busy`, `done`, accumulator and counter. No partial result is written.
- `busy`, `done`, `hi`, `lo` are registered outputs; no combinational path from inputs.

## Structure
- The shared core package holds:
  - the `op` encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the FSM state encoding;
  - the WIDTH default, shared with the ULA.
- One sub-module, `md_negate`: a conditional two's-complement unit, instantiated for operand abs (×2) and result fix-up (×2).
- The iteration datapath stays in the top module.

## Test plan
- MULT, In1 = 0xFFFFFFFD (-3), In2 = 5 → `done` at cycle 33, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; `busy` high for cycles 0–33.
- MULTU, In1 = In2 = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV -7/2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 100/7 → lo = 14, hi = 2.
- DIVU 5/0 → lo = 0xFFFFFFFF, hi = 5.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- MTHI 0x1234 with `start` re-pulsed at cycle 10 of a running MULT → both ignored; final hi/lo = the MULT result.
- `rst_n` low at cycle 15 of a DIV → hi = lo = 0, `busy` = 0 immediately, no `done`.
- Subsequent MTLO 0xAB in IDLE → lo = 0xAB the next cycle.
